lfsr_prng_gen: RTL and testbench
================================

// Module: lfsr_prng_gen
// PURPOSE
//  Parametrised Fibonacci LFSR pseudo-random generator with seed load, step enable and valid/ready word output.
//  Shifts OUT_W successive LFSR output bits into one word, then holds it until consumed.
//  The LFSR is frozen while a word waits, so the sequence is deterministic under any backpressure.
//  Sits between the board's seed source (switches/host) and random-number consumers (display, game logic).
// PARAMETERS
//  WIDTH         16        LFSR length in bits; legal 3..32
//  TAPS          16'hB400  feedback mask; bit i set => lfsr[i] in XOR; TAPS[WIDTH-1] must be 1
//  OUT_W         4         bits per output word; legal 1..WIDTH
//  DEFAULT_SEED  16'hACE1  value used at reset and on a zero seed; must be nonzero
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      asynchronous, active-low reset
//  seed_load  in   1      load seed into LFSR this cycle
//  seed       in   WIDTH  seed value, sampled when seed_load=1
//  enable     in   1      permit LFSR stepping while filling a word
//  out_valid  out  1      out_data holds a complete word
//  out_ready  in   1      consumer accepts word when out_valid&out_ready
//  out_data   out  OUT_W  random word; first generated bit in MSB
//  lfsr_state out  WIDTH  current LFSR register (debug/verification)
//  lock_err   out  1      one-cycle pulse: all-zero state detected and repaired
// BEHAVIOUR
//  Reset (rst=0, async): lfsr=DEFAULT_SEED, out_data=0, out_valid=0, bit_cnt=0, lock_err=0, state=FILL.
//  Step: fb=^(lfsr&TAPS); bit=lfsr[WIDTH-1]; lfsr<={lfsr[WIDTH-2:0],fb}; acc<={acc[OUT_W-2:0],bit}.
//  FSM states FILL, HOLD:
//   FILL: enable=1 -> one step per cycle, bit_cnt++; on step OUT_W: out_data<=final acc, out_valid<=1, bit_cnt<=0, ->HOLD.
//         enable=0 -> no step; lfsr, acc, bit_cnt held.
//   HOLD: no stepping regardless of enable; out_data/out_valid stable while out_ready=0.
//         out_valid&out_ready at edge -> out_valid<=0, ->FILL (steps resume next cycle if enable).
//  Latency: first out_valid OUT_W cycles after enable rises in FILL; sustained rate 1 word per OUT_W+1 cycles.
//  seed_load (priority over all but reset, any state): lfsr<=(seed==0 ? DEFAULT_SEED : seed); acc, bit_cnt<=0;
//   out_valid<=0; ->FILL. A handshake in the same cycle is still a valid transfer of the old word.
//  Lockup guard: if lfsr==0 at an edge (non-maximal TAPS only), lfsr<=DEFAULT_SEED, lock_err=1 for one cycle, acc/bit_cnt kept.
//  Period equals 2^WIDTH-1 when TAPS is primitive; the all-zero state is never produced by a legal load.
//  out_data unchanged when out_valid falls; only updated on FILL completion.
//  Parameter violations stop elaboration ($error in generate).
// STRUCTURE
//  lfsr_pkg: default TAPS constants per width (3..32, primitive polynomials), FSM state enum typedef.
//  Sub-module lfsr_core: WIDTH/TAPS register with step, load, zero-guard; outputs state and shifted-out bit.
//  Top: FSM, bit counter ($clog2(OUT_W+1) bits), accumulator, output handshake.
// TESTING (config WIDTH=6, TAPS=6'b110000, OUT_W=3, DEFAULT_SEED=6'b101100)
//  1 Reset release, enable=1, out_ready=1 -> after 3 cycles out_valid=1, out_data=3'b101, lfsr_state=6'b100110.
//  2 seed_load seed=0 mid-FILL -> lfsr_state=6'b101100, bit_cnt=0, out_valid=0; next word 3'b101 again.
//  3 out_ready=0 for 10 cycles in HOLD -> out_data, out_valid, lfsr_state constant; ready=1 -> valid drops next cycle.
//  4 Free-run 63 steps from 6'b101100 -> 63 distinct nonzero states, state 63 equals seed; lock_err never set.
//  5 TAPS=6'b000000 (non-primitive) seed 6'b000001 -> zero reached, lock_err one-cycle pulse, lfsr=6'b101100.
//  6 rst low mid-HOLD and mid-FILL (async, off clock edge) -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/lfsr_prng_gen_pkg.sv
// Shared types and constants for the LFSR pseudo-random word generator.
// Includes the FSM state encoding and a table of maximal-length feedback masks.
package lfsr_prng_gen_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } fsm_state_t;

  localparam int MIN_WIDTH = 3;
  localparam int MAX_WIDTH = 32;

  // Primitive-polynomial masks: bit i set means lfsr[i] feeds the XOR.
  function automatic logic [31:0] default_taps(input int width);
    logic [31:0] taps;
    case (width)
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_prng_gen_if.sv
// Valid/ready word channel carrying generated random words to a consumer.
interface lfsr_prng_gen_if #(
  parameter int OUT_W = 4
);
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/lfsr_prng_gen_core.sv
// Fibonacci LFSR register: step, seed load and all-zero repair.
// The shifted-out bit is the current MSB; `advance` tells the caller a real step happens this edge.
module lfsr_prng_gen_core #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             step,
  output logic [WIDTH-1:0] state,
  output logic             msb,
  output logic             advance,
  output logic             lock_err
);

  logic [WIDTH-1:0] lfsr_reg;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] tap_bits;
  logic             lock_err_reg;
  logic             lock_err_next;
  logic             fb;
  logic             is_zero;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_tap
      assign tap_bits[gi] = TAPS[gi] & lfsr_reg[gi];
    end
  endgenerate

  assign fb       = ^tap_bits;
  assign is_zero  = (lfsr_reg == '0);
  // A repair cycle replaces the step, so the caller must not count it as a bit.
  assign advance  = step && !load && !is_zero;
  assign state    = lfsr_reg;
  assign msb      = lfsr_reg[WIDTH-1];
  assign lock_err = lock_err_reg;

  always_comb begin
    lfsr_next     = lfsr_reg;
    lock_err_next = 1'b0;
    if (load) begin
      lfsr_next = (load_value == '0) ? DEFAULT_SEED : load_value;
    end else if (is_zero) begin
      lfsr_next     = DEFAULT_SEED;
      lock_err_next = 1'b1;
    end else if (step) begin
      lfsr_next = {lfsr_reg[WIDTH-2:0], fb};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_reg     <= DEFAULT_SEED;
      lock_err_reg <= 1'b0;
    end else begin
      lfsr_reg     <= lfsr_next;
      lock_err_reg <= lock_err_next;
    end
  end

endmodule

// File: rtl/lfsr_prng_gen.sv
// LFSR word generator: packs OUT_W successive LFSR bits into a word (first bit in MSB)
// and offers it on a valid/ready channel; the LFSR is frozen while a word waits.
module lfsr_prng_gen
  import lfsr_prng_gen_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
  parameter int               OUT_W        = 4,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1,
  // Clearing this admits masks without the top tap, which can fall into the zero state.
  parameter bit               STRICT_TAPS  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     seed_load,
  input  logic [WIDTH-1:0]         seed,
  input  logic                     enable,
  lfsr_prng_gen_if.master          out_if,
  output logic [WIDTH-1:0]         lfsr_state,
  output logic                     lock_err
);

  localparam int CNT_W = $clog2(OUT_W + 1);

  generate
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("lfsr_prng_gen: WIDTH %0d outside legal range 3..32", WIDTH);
    end
    if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
      $error("lfsr_prng_gen: OUT_W %0d outside legal range 1..WIDTH", OUT_W);
    end
    if (STRICT_TAPS && !TAPS[WIDTH-1]) begin : g_bad_taps
      $error("lfsr_prng_gen: TAPS must include bit WIDTH-1");
    end
    if (DEFAULT_SEED == '0) begin : g_bad_seed
      $error("lfsr_prng_gen: DEFAULT_SEED must be nonzero");
    end
  endgenerate

  fsm_state_t       state_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [OUT_W-1:0] acc_reg;
  logic [OUT_W-1:0] acc_shifted;
  logic [OUT_W-1:0] out_data_reg;
  logic             out_valid_reg;
  logic             core_msb;
  logic             core_advance;
  logic             step_req;
  logic             last_bit;

  assign step_req = (state_reg == ST_FILL) && enable;
  assign last_bit = (bit_cnt_reg == CNT_W'(OUT_W - 1));

  lfsr_prng_gen_core #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (seed_load),
    .load_value (seed),
    .step       (step_req),
    .state      (lfsr_state),
    .msb        (core_msb),
    .advance    (core_advance),
    .lock_err   (lock_err)
  );

  generate
    if (OUT_W == 1) begin : g_acc_single
      assign acc_shifted = core_msb;
    end else begin : g_acc_multi
      assign acc_shifted = {acc_reg[OUT_W-2:0], core_msb};
    end
  endgenerate

  // Seed load wins over the FSM; a handshake in the same cycle still consumes the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_FILL;
      bit_cnt_reg   <= '0;
      acc_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else if (seed_load) begin
      state_reg     <= ST_FILL;
      bit_cnt_reg   <= '0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_FILL: begin
          if (core_advance) begin
            acc_reg <= acc_shifted;
            if (last_bit) begin
              out_data_reg  <= acc_shifted;
              out_valid_reg <= 1'b1;
              bit_cnt_reg   <= '0;
              state_reg     <= ST_HOLD;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_valid_reg && out_if.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_FILL;
          end
        end
        default: state_reg <= ST_FILL;
      endcase
    end
  end

  assign out_if.out_valid = out_valid_reg;
  assign out_if.out_data  = out_data_reg;

endmodule

// File: tb/tb_lfsr_prng_gen.sv
// Directed plus randomized bench for lfsr_prng_gen (WIDTH=6, TAPS=6'b110000, OUT_W=3).
// Expected words come from a sequence-level model of the LFSR bit stream.
module tb_lfsr_prng_gen;

  localparam int         W     = 6;
  localparam int         OW    = 3;
  localparam logic [5:0] TP    = 6'b110000;
  localparam logic [5:0] DS    = 6'b101100;
  localparam int         TP_I  = 48;
  localparam int         DS_I  = 44;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       seed_load = 1'b0;
  logic [5:0] seed = '0;
  logic       enable = 1'b0;
  logic [5:0] lfsr_state;
  logic       lock_err;

  logic       seed_load2 = 1'b0;
  logic [5:0] seed2 = '0;
  logic       enable2 = 1'b0;
  logic [5:0] lfsr_state2;
  logic       lock_err2;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lfsr_prng_gen_if #(.OUT_W(OW)) bus ();
  lfsr_prng_gen_if #(.OUT_W(OW)) bus2 ();

  lfsr_prng_gen #(.WIDTH(W), .TAPS(TP), .OUT_W(OW), .DEFAULT_SEED(DS), .STRICT_TAPS(1'b1)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .enable(enable),
    .out_if(bus), .lfsr_state(lfsr_state), .lock_err(lock_err)
  );

  lfsr_prng_gen #(.WIDTH(W), .TAPS(6'b000000), .OUT_W(OW), .DEFAULT_SEED(DS), .STRICT_TAPS(1'b0)) dut_lock (
    .clk(clk), .rst(rst), .seed_load(seed_load2), .seed(seed2), .enable(enable2),
    .out_if(bus2), .lfsr_state(lfsr_state2), .lock_err(lock_err2)
  );

  // Sequence model: next state = 2*s + parity(s & taps), modulo 2^W; output bit = top bit of s.
  function automatic int model_next(input int s, input int taps);
    int ones = 0;
    for (int i = 0; i < W; i++) ones += (s >> i) & (taps >> i) & 1;
    return (s * 2 + ones % 2) % 64;
  endfunction

  function automatic int model_word(input int s);
    int w = 0;
    int x = s;
    for (int k = 0; k < OW; k++) begin
      w = w * 2 + x / 32;
      x = model_next(x, TP_I);
    end
    return w;
  endfunction

  function automatic int model_after(input int s);
    int x = s;
    for (int k = 0; k < OW; k++) x = model_next(x, TP_I);
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  start;
    int  d_cap, s_cap;
    int  changes, last, dups, zeros, locks, words;
    int  seen [64];
    int  v, d, s, d_prev, s_prev;
    bit  hold_prev;
    bit  found, saw_zero, early_lock;

    bus.out_ready  = 1'b0;
    bus2.out_ready = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    #10;
    check("reset_valid", 32'(bus.out_valid), 0);
    check("reset_data", 32'(bus.out_data), 0);
    check("reset_state", 32'(lfsr_state), 32'(DS));
    check("reset_lock", 32'(lock_err), 0);
    rst = 1'b1;
    enable = 1'b1;
    bus.out_ready = 1'b1;

    // First word latency: OUT_W cycles after enable
    tick();
    check("t1_c1_valid", 32'(bus.out_valid), 0);
    check("t1_c1_state", 32'(lfsr_state), 32'(model_next(DS_I, TP_I)));
    tick();
    check("t1_c2_valid", 32'(bus.out_valid), 0);
    tick();
    check("t1_valid", 32'(bus.out_valid), 1);
    check("t1_data", 32'(bus.out_data), 32'b101);
    check("t1_state", 32'(lfsr_state), 32'b100110);
    check("t1_model_word", 32'(bus.out_data), 32'(model_word(DS_I)));
    $display("word: data=%0h state=%0h", bus.out_data, lfsr_state);
    tick();
    check("t1_consume_valid", 32'(bus.out_valid), 0);
    check("t1_consume_data", 32'(bus.out_data), 32'b101);
    check("t1_consume_state", 32'(lfsr_state), 32'b100110);
    tick();
    check("t1_resume_state", 32'(lfsr_state), 32'(model_next(38, TP_I)));

    // Zero seed load mid-fill falls back to the default seed
    seed_load = 1'b1;
    seed = 6'd0;
    tick();
    seed_load = 1'b0;
    check("t2_state", 32'(lfsr_state), 32'(DS));
    check("t2_valid", 32'(bus.out_valid), 0);
    tick();
    tick();
    check("t2_c2_valid", 32'(bus.out_valid), 0);
    tick();
    check("t2_valid_again", 32'(bus.out_valid), 1);
    check("t2_data", 32'(bus.out_data), 32'b101);
    $display("word: data=%0h state=%0h", bus.out_data, lfsr_state);

    // Backpressure holds word and LFSR frozen
    bus.out_ready = 1'b0;
    d_cap = 32'(bus.out_data);
    s_cap = 32'(lfsr_state);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_valid", 32'(bus.out_valid), 1);
      check("t3_hold_data", 32'(bus.out_data), 32'(d_cap));
      check("t3_hold_state", 32'(lfsr_state), 32'(s_cap));
    end
    bus.out_ready = 1'b1;
    tick();
    check("t3_drop_valid", 32'(bus.out_valid), 0);
    check("t3_drop_data", 32'(bus.out_data), 32'(d_cap));

    // Full period from the default seed
    seed_load = 1'b1;
    seed = DS;
    tick();
    seed_load = 1'b0;
    foreach (seen[i]) seen[i] = 0;
    changes = 0; last = DS_I; dups = 0; zeros = 0; locks = 0;
    for (int c = 0; c < 300 && changes < 63; c++) begin
      tick();
      if (lock_err) locks++;
      if (32'(lfsr_state) != last) begin
        changes++;
        if (lfsr_state == 6'd0) zeros++;
        if (seen[lfsr_state] != 0) dups++;
        seen[lfsr_state] = 1;
        if (32'(lfsr_state) != model_next(last, TP_I)) begin
          check("t4_step", 32'(lfsr_state), 32'(model_next(last, TP_I)));
        end
        last = 32'(lfsr_state);
      end
    end
    check("t4_steps", 32'(changes), 63);
    check("t4_dups", 32'(dups), 0);
    check("t4_zeros", 32'(zeros), 0);
    check("t4_last_is_seed", 32'(last), 32'(DS));
    check("t4_no_lock", 32'(locks), 0);

    // Randomized enable/ready/seed traffic against the sequence model
    seed_load = 1'b1;
    seed = 6'($urandom_range(1, 63));
    tick();
    seed_load = 1'b0;
    start = 32'(seed);
    hold_prev = 1'b0; d_prev = 0; s_prev = 0; words = 0;
    for (int c = 0; c < 400; c++) begin
      v = 32'(bus.out_valid);
      d = 32'(bus.out_data);
      s = 32'(lfsr_state);
      check("rand_no_lock", 32'(lock_err), 0);
      if (hold_prev) begin
        check("rand_hold_valid", 32'(v), 1);
        check("rand_hold_data", 32'(d), 32'(d_prev));
        check("rand_hold_state", 32'(s), 32'(s_prev));
      end
      enable        = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 1) != 0);
      seed_load     = ($urandom_range(0, 19) == 0);
      seed          = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      if (v == 1 && bus.out_ready) begin
        check("rand_word", 32'(d), 32'(model_word(start)));
        check("rand_word_state", 32'(s), 32'(model_after(start)));
        $display("word: data=%0h state=%0h", d, s);
        start = model_after(start);
        words++;
      end
      if (seed_load) start = (seed == 6'd0) ? DS_I : 32'(seed);
      hold_prev = (v == 1) && !bus.out_ready && !seed_load;
      d_prev = d;
      s_prev = s;
      tick();
    end
    seed_load = 1'b0;
    check("rand_enough_words", 32'(words >= 10), 1);

    // Lockup repair on the degenerate-mask instance
    bus2.out_ready = 1'b1;
    enable2 = 1'b1;
    seed_load2 = 1'b1;
    seed2 = 6'b000001;
    tick();
    seed_load2 = 1'b0;
    check("t5_loaded", 32'(lfsr_state2), 1);
    found = 1'b0; saw_zero = 1'b0; early_lock = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (lock_err2) begin
        found = 1'b1;
        check("t5_repaired_state", 32'(lfsr_state2), 32'(DS));
      end else if (lfsr_state2 == 6'd0) begin
        saw_zero = 1'b1;
      end
    end
    check("t5_lock_seen", 32'(found), 1);
    check("t5_zero_seen", 32'(saw_zero), 1);
    tick();
    check("t5_lock_one_cycle", 32'(lock_err2), 0);
    early_lock = lock_err2;
    check("t5_no_relock", 32'(early_lock), 0);

    // Asynchronous reset mid-hold
    enable = 1'b1;
    bus.out_ready = 1'b0;
    seed_load = 1'b1;
    seed = DS;
    tick();
    seed_load = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (bus.out_valid) found = 1'b1;
    end
    check("t6_hold_reached", 32'(found), 1);
    check("t6_hold_data", 32'(bus.out_data), 32'b101);
    #2 rst = 1'b0;
    #1;
    check("t6_hold_rst_valid", 32'(bus.out_valid), 0);
    check("t6_hold_rst_data", 32'(bus.out_data), 0);
    check("t6_hold_rst_state", 32'(lfsr_state), 32'(DS));
    check("t6_hold_rst_lock", 32'(lock_err), 0);
    #1 rst = 1'b1;

    // Asynchronous reset mid-fill
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("t6_fill_state", 32'(lfsr_state), 32'(model_next(model_next(DS_I, TP_I), TP_I)));
    #2 rst = 1'b0;
    #1;
    check("t6_fill_rst_valid", 32'(bus.out_valid), 0);
    check("t6_fill_rst_data", 32'(bus.out_data), 0);
    check("t6_fill_rst_state", 32'(lfsr_state), 32'(DS));
    check("t6_fill_rst_state2", 32'(lfsr_state2), 32'(DS));
    check("t6_fill_rst_lock", 32'(lock_err), 0);
    #1 rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
